// File: rtl/shift_reg_universal_pkg.sv
// Shared definitions for the universal shift register: mode encodings and counter width.
package shift_reg_universal_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a shift count of 0..width.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Frame counter for the universal shift register: counts shifts and emits a registered
// one-cycle wrap pulse when the WIDTH-th shift of a frame completes.
module shift_bit_counter
    import shift_reg_universal_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt,
    output logic          o_wrap
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_wrap;

    // Count shifts; wrap to zero and pulse on the last bit of a frame, clear on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (i_inc) begin
            if (r_cnt == LAST) begin
                r_cnt  <= '0;
                r_wrap <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CW'(1);
                r_wrap <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: shift left/right with serial or rotate input, parallel load,
// hold, plus a shift counter with a frame-complete pulse for SIPO/PISO use.
module shift_reg_universal
    import shift_reg_universal_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    localparam int unsigned         CW        = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rotate,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic [CW-1:0]    bit_cnt,
    output logic             frame_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_bit_l;
    logic             w_bit_r;
    logic             w_shift;
    logic             w_load;

    assign w_bit_l = rotate ? r_q[WIDTH-1] : ser_in;
    assign w_bit_r = rotate ? r_q[0] : ser_in;
    assign w_shift = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
    assign w_load  = en && (mode == MODE_LOAD);

    // Datapath mux; any mode not explicitly decoded (including unknowns) holds.
    always_comb begin
        w_q_next = r_q;
        if (en) begin
            case (mode)
                MODE_SHL:  w_q_next = {r_q[WIDTH-2:0], w_bit_l};
                MODE_SHR:  w_q_next = {w_bit_r, r_q[WIDTH-1:1]};
                MODE_LOAD: w_q_next = par_in;
                default:   w_q_next = r_q;
            endcase
        end
    end

    // Register contents; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .reset  (reset),
        .i_inc  (w_shift),
        .i_clr  (w_load),
        .o_cnt  (bit_cnt),
        .o_wrap (frame_done)
    );

    assign q           = r_q;
    assign ser_out_msb = r_q[WIDTH-1];
    assign ser_out_lsb = r_q[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Directed self-checking bench for shift_reg_universal (WIDTH=8, plus a RESET_VAL=A5 copy).
module tb_shift_reg_universal;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       rotate;
    logic       ser_in;
    logic [7:0] par_in;

    logic [7:0] q;
    logic       ser_out_msb;
    logic       ser_out_lsb;
    logic [3:0] bit_cnt;
    logic       frame_done;

    logic [7:0] q2;
    logic       msb2;
    logic       lsb2;
    logic [3:0] cnt2;
    logic       done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_reg_universal #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .rotate      (rotate),
        .ser_in      (ser_in),
        .par_in      (par_in),
        .q           (q),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .bit_cnt     (bit_cnt),
        .frame_done  (frame_done)
    );

    shift_reg_universal #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut_a5 (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .rotate      (rotate),
        .ser_in      (ser_in),
        .par_in      (par_in),
        .q           (q2),
        .ser_out_msb (msb2),
        .ser_out_lsb (lsb2),
        .bit_cnt     (cnt2),
        .frame_done  (done2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock, then settle past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic rot, input logic s);
        en     = e;
        mode   = m;
        rotate = rot;
        ser_in = s;
        tick();
    endtask

    task automatic load(input logic [7:0] v);
        par_in = v;
        drive(1'b1, 2'b11, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] stream;
        logic [7:0] exp_q2;
        logic [7:0] exp_msb;
        logic [7:0] rot_seq [8];

        reset  = 1'b1;
        en     = 1'b0;
        mode   = 2'b00;
        rotate = 1'b0;
        ser_in = 1'b0;
        par_in = 8'h00;
        tick();
        reset = 1'b0;

        // 1. Dirty the register, then reset.
        load(8'hFF);
        check_val("load_ff", 32'(q), 32'hFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_q", 32'(q), 32'h00);
        check_val("rst_cnt", 32'(bit_cnt), 32'd0);
        check_val("rst_done", 32'(frame_done), 32'd0);
        check_val("rst_q_a5", 32'(q2), 32'hA5);

        // 2. SIPO left shift of 1,0,1,1,0,0,1,0.
        stream = 8'b1011_0010;
        exp_q2 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b01, 1'b0, stream[7-i]);
            exp_q2 = {exp_q2[6:0], stream[7-i]};
            check_val("sipo_q", 32'(q), 32'(exp_q2));
            check_val("sipo_done", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
            check_val("sipo_cnt", 32'(bit_cnt), (i == 7) ? 32'd0 : 32'(i + 1));
        end
        check_val("sipo_final", 32'(q), 32'hB2);

        // Hold mode: q and count stay, pulse drops.
        drive(1'b1, 2'b00, 1'b0, 1'b1);
        check_val("hold_q", 32'(q), 32'hB2);
        check_val("hold_done", 32'(frame_done), 32'd0);

        // 3. Load 81, rotate right eight times.
        load(8'h81);
        check_val("load81_lsb", 32'(ser_out_lsb), 32'd1);
        check_val("load81_cnt", 32'(bit_cnt), 32'd0);
        rot_seq = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'b10, 1'b1, 1'b0);
            check_val("ror_q", 32'(q), 32'(rot_seq[i]));
            check_val("ror_done", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end

        // 4. PISO: load 3C, shift out MSB-first with zero fill.
        load(8'h3C);
        check_val("load3c_lsb", 32'(ser_out_lsb), 32'd0);
        exp_msb = 8'b0011_1100;
        for (int i = 0; i < 8; i++) begin
            check_val("piso_msb", 32'(ser_out_msb), 32'(exp_msb[7-i]));
            drive(1'b1, 2'b01, 1'b0, 1'b0);
        end
        check_val("piso_empty", 32'(q), 32'h00);
        check_val("piso_done", 32'(frame_done), 32'd1);

        // 5. Enable gap mid-frame: 5 shifts, 3 idle, 3 shifts.
        load(8'h00);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b1);
            check_val("gap_pre_done", 32'(frame_done), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b01, 1'b0, 1'b0);
            check_val("gap_idle_done", 32'(frame_done), 32'd0);
            check_val("gap_idle_cnt", 32'(bit_cnt), 32'd5);
            check_val("gap_idle_q", 32'(q), 32'h1F);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b1);
            check_val("gap_post_done", 32'(frame_done), (i == 2) ? 32'd1 : 32'd0);
        end
        check_val("gap_q", 32'(q), 32'hFF);

        // 6. Reset mid-frame, then two back-to-back frames.
        load(8'h00);
        for (int i = 0; i < 4; i++) drive(1'b1, 2'b01, 1'b0, 1'b1);
        check_val("mid_cnt", 32'(bit_cnt), 32'd4);
        check_val("mid_q", 32'(q), 32'h0F);
        reset = 1'b1;
        drive(1'b1, 2'b01, 1'b0, 1'b1);
        reset = 1'b0;
        check_val("midrst_cnt", 32'(bit_cnt), 32'd0);
        check_val("midrst_q", 32'(q), 32'h00);
        check_val("midrst_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i < 4) ? 2'b01 : 2'b10, 1'b0, 1'b1);
            check_val("b2b_done", 32'(frame_done), ((i == 7) || (i == 15)) ? 32'd1 : 32'd0);
        end
        check_val("b2b_q", 32'(q), 32'hFF);
        check_val("b2b_cnt", 32'(bit_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
